// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter
// Round-robin owner of the two-digit hex display shared by three requesters.
// The winner's byte is captured at grant and held until the next grant. A slot
// ends after HOLD_CYCLES cycles or when the owner drops its request. The
// owner's done bit pulses for one cycle when its slot ends. Every output comes
// straight from a register.

module hex_display_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic [8:0] disp_word,
  output logic [1:0] disp_src,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Terminal count value: the slot ends on the edge where the counter holds it.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]       NO_OWNER = 2'd3;

  // First requesting index after 'last', searching (last+1), (last+2), last.
  // Returns NO_OWNER when nobody is requesting.
  function automatic logic [1:0] pick_winner(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] w;
    w = NO_OWNER;
    case (last)
      2'd0: begin
        if (r[1])      w = 2'd1;
        else if (r[2]) w = 2'd2;
        else if (r[0]) w = 2'd0;
        else           w = NO_OWNER;
      end
      2'd1: begin
        if (r[2])      w = 2'd2;
        else if (r[0]) w = 2'd0;
        else if (r[1]) w = 2'd1;
        else           w = NO_OWNER;
      end
      default: begin
        if (r[0])      w = 2'd0;
        else if (r[1]) w = 2'd1;
        else if (r[2]) w = 2'd2;
        else           w = NO_OWNER;
      end
    endcase
    return w;
  endfunction

  // One-hot code for an owner index; NO_OWNER maps to no bits set.
  function automatic logic [2:0] onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  state_t           state_r,      state_s;
  logic [CNT_W-1:0] cnt_r,        cnt_s;
  logic [1:0]       last_owner_r, last_owner_s;
  logic [2:0]       grant_r,      grant_s;
  logic [2:0]       done_r,       done_s;
  logic [8:0]       disp_word_r,  disp_word_s;
  logic [1:0]       disp_src_r,   disp_src_s;
  logic             busy_r,       busy_s;

  logic [1:0]       winner_s;
  logic [7:0]       winner_data_s;
  logic             owner_req_s;
  logic             slot_end_s;

  // Arbitration result and the byte belonging to the winner.
  always_comb begin
    winner_s      = pick_winner(req, last_owner_r);
    winner_data_s = 8'h00;
    case (winner_s)
      2'd0:    winner_data_s = data0;
      2'd1:    winner_data_s = data1;
      2'd2:    winner_data_s = data2;
      default: winner_data_s = 8'h00;
    endcase
  end

  // Slot end: hold time used up, or the owner has let go of its request.
  always_comb begin
    owner_req_s = |(req & grant_r);
    if ((cnt_r == LAST_CNT) || !owner_req_s) begin
      slot_end_s = 1'b1;
    end else begin
      slot_end_s = 1'b0;
    end
  end

  // Next-state and next-output logic; the grant/exit edges update all outputs together.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    last_owner_s = last_owner_r;
    grant_s      = grant_r;
    done_s       = 3'b000;
    disp_word_s  = disp_word_r;
    disp_src_s   = disp_src_r;
    busy_s       = busy_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s     = SHOW;
          grant_s     = onehot(winner_s);
          disp_src_s  = winner_s;
          disp_word_s = {1'b1, winner_data_s};
          cnt_s       = {CNT_W{1'b0}};
          busy_s      = 1'b1;
        end else begin
          state_s     = IDLE;
        end
      end
      SHOW: begin
        if (slot_end_s) begin
          state_s        = IDLE;
          grant_s        = 3'b000;
          done_s         = grant_r;
          last_owner_s   = disp_src_r;
          disp_src_s     = NO_OWNER;
          disp_word_s[8] = 1'b0;
          busy_s         = 1'b0;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s        = IDLE;
        grant_s        = 3'b000;
        disp_src_s     = NO_OWNER;
        disp_word_s[8] = 1'b0;
        busy_s         = 1'b0;
        cnt_s          = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      last_owner_r <= 2'd2;
      grant_r      <= 3'b000;
      done_r       <= 3'b000;
      disp_word_r  <= 9'h000;
      disp_src_r   <= NO_OWNER;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      last_owner_r <= last_owner_s;
      grant_r      <= grant_s;
      done_r       <= done_s;
      disp_word_r  <= disp_word_s;
      disp_src_r   <= disp_src_s;
      busy_r       <= busy_s;
    end
  end

  assign grant     = grant_r;
  assign done      = done_r;
  assign disp_word = disp_word_r;
  assign disp_src  = disp_src_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with HOLD_CYCLES=4.
// Inputs change and outputs are sampled on the falling edge.

module tb_hex_display_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [7:0] data0, data1, data2;
  logic [2:0] grant, done;
  logic [8:0] disp_word;
  logic [1:0] disp_src;
  logic       busy;

  int checks_r;
  int errors_r;

  hex_display_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant), .done(done), .disp_word(disp_word),
    .disp_src(disp_src), .busy(busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] g, input logic [2:0] d,
                           input logic [8:0] w, input logic [1:0] s, input logic b);
    check({tag, ".grant"}, {13'd0, grant}, {13'd0, g});
    check({tag, ".done"},  {13'd0, done},  {13'd0, d});
    check({tag, ".word"},  {7'd0, disp_word}, {7'd0, w});
    check({tag, ".src"},   {14'd0, disp_src}, {14'd0, s});
    check({tag, ".busy"},  {15'd0, busy},  {15'd0, b});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset for two cycles with the given request pattern, checking reset values.
  task automatic do_reset(input logic [2:0] r);
    rst = 1'b1;
    req = r;
    step();
    check_all("rst_a", 3'b000, 3'b000, 9'h000, 2'd3, 1'b0);
    step();
    check_all("rst_b", 3'b000, 3'b000, 9'h000, 2'd3, 1'b0);
    rst = 1'b0;
  endtask

  // Entered just after the grant edge: four owned cycles, then the IDLE/done cycle.
  task automatic slot(input string tag, input logic [1:0] owner, input logic [7:0] b);
    logic [2:0] oh;
    oh = 3'b001 << owner;
    for (int i = 0; i < 4; i++) begin
      check_all(tag, oh, 3'b000, {1'b1, b}, owner, 1'b1);
      step();
    end
    check_all({tag, "_done"}, 3'b000, oh, {1'b0, b}, 2'd3, 1'b0);
    step();
  endtask

  initial begin
    checks_r = 0;
    errors_r = 0;
    rst   = 1'b1;
    req   = 3'b000;
    data0 = 8'h11;
    data1 = 8'h22;
    data2 = 8'h33;
    @(negedge clk);

    // Reset with every requester active, then round robin 0,1,2,0.
    do_reset(3'b111);
    step();
    slot("rr0", 2'd0, 8'h11);
    slot("rr1", 2'd1, 8'h22);
    slot("rr2", 2'd2, 8'h33);
    slot("rr0b", 2'd0, 8'h11);

    // Single requester held: full slot, done, then regrant.
    do_reset(3'b001);
    data0 = 8'hA5;
    step();
    slot("single", 2'd0, 8'hA5);
    check_all("regrant", 3'b001, 3'b000, 9'h1A5, 2'd0, 1'b1);

    // Early release by requester 1 after two owned cycles.
    do_reset(3'b010);
    data1 = 8'h5C;
    step();
    check_all("er_c1", 3'b010, 3'b000, 9'h15C, 2'd1, 1'b1);
    step();
    check_all("er_c2", 3'b010, 3'b000, 9'h15C, 2'd1, 1'b1);
    req = 3'b000;
    step();
    check_all("er_exit", 3'b000, 3'b010, 9'h05C, 2'd3, 1'b0);
    step();
    check_all("er_idle", 3'b000, 3'b000, 9'h05C, 2'd3, 1'b0);

    // Snapshot frozen during SHOW; a short req2 pulse is never served.
    do_reset(3'b001);
    data0 = 8'h0F;
    step();
    check_all("snap_c1", 3'b001, 3'b000, 9'h10F, 2'd0, 1'b1);
    data0 = 8'hF0;
    req   = 3'b101;
    step();
    check_all("snap_c2", 3'b001, 3'b000, 9'h10F, 2'd0, 1'b1);
    req = 3'b001;
    step();
    step();
    check_all("snap_c4", 3'b001, 3'b000, 9'h10F, 2'd0, 1'b1);
    step();
    check_all("snap_done", 3'b000, 3'b001, 9'h00F, 2'd3, 1'b0);
    step();
    check_all("snap_regrant", 3'b001, 3'b000, 9'h1F0, 2'd0, 1'b1);

    // Reset in the middle of a slot, then requester 1 wins from reset priority.
    do_reset(3'b001);
    data0 = 8'hAA;
    data1 = 8'h77;
    step();
    step();
    step();
    check_all("mid_cnt2", 3'b001, 3'b000, 9'h1AA, 2'd0, 1'b1);
    rst = 1'b1;
    req = 3'b110;
    step();
    check_all("mid_rst", 3'b000, 3'b000, 9'h000, 2'd3, 1'b0);
    rst = 1'b0;
    step();
    check_all("mid_grant", 3'b010, 3'b000, 9'h177, 2'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
